// File: rtl/fact_accel_mm.sv
// fact_accel_mm: register-mapped iterative factorial accelerator with sticky overflow flag and level interrupt
//   clk, rst     : clock, asynchronous active-high reset
//   WE, A, WD    : write enable, register address (0=N 1=CTRL 2=STATUS 3=RESULT), write data
//   RD           : combinational read data for address A
//   irq          : done && ie
module fact_accel_mm #(
  parameter int NW = 4,
  parameter int RW = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WE,
  input  logic [1:0]  A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        irq
);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state_q;
  logic [NW-1:0] n_q, cnt_q;
  logic [RW-1:0] acc_q, result_q;
  logic ie_q, done_q, err_q;
  logic go_d, busy;
  logic [RW+NW-1:0] prod_d;
  assign go_d   = WE && A == 2'd1 && WD[0];
  assign busy   = state_q == MUL;
  assign prod_d = (RW+NW)'(acc_q) * (RW+NW)'(cnt_q);
  assign irq    = done_q && ie_q;
  always_comb
    RD = A == 2'd0 ? 32'(n_q) :
         A == 2'd1 ? {30'b0, ie_q, 1'b0} :
         A == 2'd2 ? {29'b0, err_q, busy, done_q} : 32'(result_q);
  // W1C is applied first so that flag updates from the FSM below win on the same edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ie_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (WE && A == 2'd0) n_q <= WD[NW-1:0];
      if (WE && A == 2'd1) ie_q <= WD[1];
      if (WE && A == 2'd2 && WD[0]) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      case (state_q)
        IDLE: if (go_d) begin
          acc_q   <= RW'(1);
          cnt_q   <= n_q;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= MUL;
        end
        MUL: if (cnt_q > NW'(1)) begin
          acc_q <= prod_d[RW-1:0];
          cnt_q <= cnt_q - NW'(1);
          if (|prod_d[RW+NW-1:RW]) err_q <= 1'b1;
        end else begin
          result_q <= acc_q;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fact_accel_mm.sv
// tb_fact_accel_mm: randomized self-checking bench for fact_accel_mm against an exact-factorial model
module tb_fact_accel_mm;
  logic clk = 1'b0, rst = 1'b1, WE = 1'b0, irq;
  logic [1:0] A = 2'd0;
  logic [31:0] WD = '0, RD;
  int n_tests = 0, n_fail = 0;

  fact_accel_mm #(.NW(4), .RW(32)) dut (
    .clk(clk), .rst(rst), .WE(WE), .A(A), .WD(WD), .RD(RD), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  // all driving and sampling happens just after a falling edge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    WE = 1'b1; A = a; WD = d;
    @(negedge clk);
    WE = 1'b0; WD = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    A = a; #1; v = RD;
  endtask

  // exact n! in 64 bits; overflow of any running product equals overflow of the final one
  function automatic longint unsigned fact(input int n);
    longint unsigned f = 1;
    for (int k = 2; k <= n; k++) f *= longint'(k);
    return f;
  endfunction

  task automatic wait_done(output int cyc);
    logic [31:0] st;
    cyc = 0;
    rd(2, st);
    while (!st[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
      rd(2, st);
    end
  endtask

  task automatic run(input string tag, input int n, input bit ie);
    logic [31:0] v;
    longint unsigned f;
    int cyc;
    f = fact(n);
    wr(0, n);
    wr(1, {30'b0, ie, 1'b1});
    rd(2, v);
    chk({tag, ".busy"}, v[1], 1);
    wait_done(cyc);
    chk({tag, ".lat"}, cyc, n > 1 ? n : 1);
    rd(3, v);
    chk({tag, ".res"}, v, f[31:0]);
    rd(2, v);
    chk({tag, ".stat"}, v, {29'b0, f > 64'hFFFF_FFFF, 2'b01});
    chk({tag, ".irq"}, irq, ie);
  endtask

  task automatic chk_zero(input string tag);
    logic [31:0] v;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      chk($sformatf("%s.rd%0d", tag, a), v, 0);
    end
    chk({tag, ".irq"}, irq, 0);
  endtask

  initial begin
    logic [31:0] v;
    int cyc;
    @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;
    @(negedge clk);
    run("n5", 5, 0);
    run("n12", 12, 0);
    run("n13", 13, 0);
    wr(2, 1);
    rd(2, v);
    chk("w1c.err", v, 0);
    run("n0", 0, 0);
    run("n1", 1, 0);
    run("ie4", 4, 1);
    wr(2, 1);
    chk("ie4.irqclr", irq, 0);
    rd(2, v);
    chk("ie4.doneclr", v[0], 0);
    wr(1, 0);
    // go ignored while busy, N still updates
    wr(0, 7);
    wr(1, 1);
    wr(0, 3);
    wr(1, 1);
    wait_done(cyc);
    rd(3, v);
    chk("busy_go.res", v, 5040);
    rd(0, v);
    chk("busy_go.n", v, 3);
    // W1C landing on the edge that sets done: done survives
    wr(0, 2);
    wr(1, 1);
    @(negedge clk);
    wr(2, 1);
    rd(2, v);
    chk("w1c_race", v, 1);
    // reset mid-run
    wr(0, 9);
    wr(1, 3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    // go on the first edge after reset release (N=0 after reset)
    rst = 1'b0;
    wr(1, 1);
    rd(2, v);
    chk("postrst.busy", v, 2);
    @(negedge clk);
    rd(3, v);
    chk("postrst.res", v, 1);
    run("n3", 3, 0);
    for (int i = 0; i < 20; i++) run($sformatf("rnd%0d", i), $urandom_range(0, 15), 1'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
